// File: rtl/control_unit.sv
// control_unit -- RV32I main decoder.
// Combinational decode of OP/Funct3/Funct7 into datapath control strobes,
// plus a registered sticky flag that reports any illegal encoding seen since
// the last reset.
// Build option: define CU_SYSTEM_EN to accept FENCE and SYSTEM opcodes as
// legal NOPs; when undefined they are treated as illegal encodings.

module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] OP,
  input  logic [2:0] Funct3,
  input  logic [6:0] Funct7,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       Jump,
  output logic       JumpSrc,
  output logic       MemtoReg,
  output logic       Branch,
  output logic [1:0] ALUSrcB,
  output logic       ALUResult,
  output logic       ALUSrcA,
  output logic [1:0] RegSrc,
  output logic [2:0] LoadOrStoreTYPE,
  output logic       IllegalInstr
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
`ifdef CU_SYSTEM_EN
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
`endif

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  logic legal;
  logic illegal_q;
  logic illegal_d;

  // Legality check of the current encoding; anything not explicitly accepted is illegal.
  always_comb begin
    legal = 1'b0;
    case (OP)
      OP_R: begin
        // Only SUB and SRA use the alternate Funct7.
        legal = (Funct7 == F7_BASE) ||
                ((Funct7 == F7_ALT) && ((Funct3 == 3'b000) || (Funct3 == 3'b101)));
      end
      OP_IALU: begin
        // Funct7 is part of the immediate except for the shift forms.
        case (Funct3)
          3'b001:  legal = (Funct7 == F7_BASE);
          3'b101:  legal = (Funct7 == F7_BASE) || (Funct7 == F7_ALT);
          default: legal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        legal = !((Funct3 == 3'b011) || (Funct3 == 3'b110) || (Funct3 == 3'b111));
      end
      OP_STORE: begin
        legal = (Funct3 <= 3'b010);
      end
      OP_BRANCH: begin
        legal = !((Funct3 == 3'b010) || (Funct3 == 3'b011));
      end
      OP_JAL: begin
        legal = 1'b1;
      end
      OP_JALR: begin
        legal = (Funct3 == 3'b000);
      end
      OP_LUI: begin
        legal = 1'b1;
      end
      OP_AUIPC: begin
        legal = 1'b1;
      end
`ifdef CU_SYSTEM_EN
      OP_FENCE: begin
        legal = 1'b1;
      end
      OP_SYSTEM: begin
        legal = 1'b1;
      end
`else
`endif
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // Control strobe decode; an illegal encoding leaves every strobe at 0 (NOP).
  always_comb begin
    RegWrite        = 1'b0;
    MemWrite        = 1'b0;
    Jump            = 1'b0;
    JumpSrc         = 1'b0;
    MemtoReg        = 1'b0;
    Branch          = 1'b0;
    ALUSrcB         = SRCB_RS2;
    ALUResult       = 1'b0;
    ALUSrcA         = 1'b0;
    RegSrc          = WB_ALU;
    LoadOrStoreTYPE = 3'b000;
    if (legal) begin
      case (OP)
        OP_R: begin
          RegWrite  = 1'b1;
          ALUResult = 1'b1;
        end
        OP_IALU: begin
          RegWrite  = 1'b1;
          ALUSrcB   = SRCB_IMM;
          ALUResult = 1'b1;
        end
        OP_LOAD: begin
          RegWrite        = 1'b1;
          MemtoReg        = 1'b1;
          ALUSrcB         = SRCB_IMM;
          RegSrc          = WB_MEM;
          LoadOrStoreTYPE = Funct3;
        end
        OP_STORE: begin
          MemWrite        = 1'b1;
          ALUSrcB         = SRCB_IMM;
          LoadOrStoreTYPE = Funct3;
        end
        OP_BRANCH: begin
          // ALU compares rs1/rs2; Funct3 selects the branch condition.
          Branch    = 1'b1;
          ALUResult = 1'b1;
        end
        OP_JAL: begin
          RegWrite = 1'b1;
          Jump     = 1'b1;
          JumpSrc  = 1'b0;
          RegSrc   = WB_PC4;
        end
        OP_JALR: begin
          RegWrite = 1'b1;
          Jump     = 1'b1;
          JumpSrc  = 1'b1;
          ALUSrcB  = SRCB_IMM;
          RegSrc   = WB_PC4;
        end
        OP_LUI: begin
          RegWrite = 1'b1;
          RegSrc   = WB_IMM;
        end
        OP_AUIPC: begin
          RegWrite = 1'b1;
          ALUSrcA  = 1'b1;
          ALUSrcB  = SRCB_IMM;
        end
        default: begin
          // FENCE/SYSTEM (when enabled) decode as NOP: defaults stand.
        end
      endcase
    end
  end

  // Sticky flag next state: once an illegal encoding is seen it holds.
  always_comb begin
    illegal_d = illegal_q | ~legal;
  end

  // Sticky flag register; synchronous reset dominates a coincident illegal encoding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign IllegalInstr = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed vector table, reset/sticky sequences and
// randomized encodings checked against a table-driven reference model.
// Honours CU_SYSTEM_EN the same way as the design build.

module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic [6:0] OP;
  logic [2:0] Funct3;
  logic [6:0] Funct7;
  logic       RegWrite, MemWrite, Jump, JumpSrc, MemtoReg, Branch;
  logic [1:0] ALUSrcB;
  logic       ALUResult, ALUSrcA;
  logic [1:0] RegSrc;
  logic [2:0] LoadOrStoreTYPE;
  logic       IllegalInstr;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .OP(OP), .Funct3(Funct3), .Funct7(Funct7),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .Jump(Jump), .JumpSrc(JumpSrc),
    .MemtoReg(MemtoReg), .Branch(Branch), .ALUSrcB(ALUSrcB), .ALUResult(ALUResult),
    .ALUSrcA(ALUSrcA), .RegSrc(RegSrc), .LoadOrStoreTYPE(LoadOrStoreTYPE),
    .IllegalInstr(IllegalInstr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CU_SYSTEM_EN
  localparam bit SYS_ILL = 1'b0;
`else
  localparam bit SYS_ILL = 1'b1;
`endif

  // {RegWrite,MemWrite,Jump,JumpSrc,MemtoReg,Branch,ALUSrcB,ALUResult,ALUSrcA,RegSrc,LST}
  logic [14:0] act_out;
  assign act_out = {RegWrite, MemWrite, Jump, JumpSrc, MemtoReg, Branch, ALUSrcB,
                    ALUResult, ALUSrcA, RegSrc, LoadOrStoreTYPE};

  int total = 0;
  int bad   = 0;
  bit model_flag = 1'b0;

  function automatic logic [14:0] mk(bit rw, bit mw, bit j, bit js, bit m2r, bit br,
                                     logic [1:0] asb, bit ares, bit asa,
                                     logic [1:0] rs, logic [2:0] lst);
    return {rw, mw, j, js, m2r, br, asb, ares, asa, rs, lst};
  endfunction

  // Reference model: per-opcode rows with a bitmap of accepted Funct3 values.
  typedef struct {
    logic [6:0]  op;
    logic [7:0]  f3_ok;
    logic [14:0] base;
    bit          lst_f3;
  } row_t;
  row_t rows[$];

  function automatic void ref_model(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [6:0] f7,
                                    output logic [14:0] o, output bit ill);
    bit ok;
    o   = '0;
    ill = 1'b1;
    foreach (rows[i]) begin
      if (rows[i].op == op) begin
        ok = rows[i].f3_ok[f3];
        if (op == 7'b0110011)
          ok = ok && ((f7 == 7'd0) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        if (op == 7'b0010011 && f3 == 3'd1) ok = ok && (f7 == 7'd0);
        if (op == 7'b0010011 && f3 == 3'd5) ok = ok && (f7 == 7'd0 || f7 == 7'h20);
        if (ok) begin
          ill = 1'b0;
          o   = rows[i].base | (rows[i].lst_f3 ? {12'd0, f3} : 15'd0);
        end
      end
    end
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (OP=%b F3=%b F7=%b)", name, act, exp, OP, Funct3, Funct7);
    end
  endtask

  // One cycle: drive, check combinational outputs, clock, check the sticky flag.
  task automatic apply(input string name, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input bit rn,
                       input logic [14:0] exp_o, input bit exp_ill);
    OP = op; Funct3 = f3; Funct7 = f7; rst_n = rn;
    #1;
    check({name, ".out"}, act_out, exp_o);
    @(posedge clk);
    model_flag = rn ? (model_flag | exp_ill) : 1'b0;
    #1;
    check({name, ".flag"}, {14'd0, IllegalInstr}, {14'd0, model_flag});
  endtask

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [14:0] exp_o;
    bit          ill;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t v(string n, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                             logic [14:0] e, bit ill);
    vec_t t;
    t.name = n; t.op = op; t.f3 = f3; t.f7 = f7; t.exp_o = e; t.ill = ill;
    return t;
  endfunction

  initial begin
    logic [14:0] eo;
    bit          ei;
    logic [6:0]  rop;
    logic [6:0]  ops [12];

    rows.push_back('{7'b0110011, 8'hFF, mk(1,0,0,0,0,0,2'b00,1,0,2'b00,3'b0), 1'b0});
    rows.push_back('{7'b0010011, 8'hFF, mk(1,0,0,0,0,0,2'b01,1,0,2'b00,3'b0), 1'b0});
    rows.push_back('{7'b0000011, 8'h37, mk(1,0,0,0,1,0,2'b01,0,0,2'b01,3'b0), 1'b1});
    rows.push_back('{7'b0100011, 8'h07, mk(0,1,0,0,0,0,2'b01,0,0,2'b00,3'b0), 1'b1});
    rows.push_back('{7'b1100011, 8'hF3, mk(0,0,0,0,0,1,2'b00,1,0,2'b00,3'b0), 1'b0});
    rows.push_back('{7'b1101111, 8'hFF, mk(1,0,1,0,0,0,2'b00,0,0,2'b10,3'b0), 1'b0});
    rows.push_back('{7'b1100111, 8'h01, mk(1,0,1,1,0,0,2'b01,0,0,2'b10,3'b0), 1'b0});
    rows.push_back('{7'b0110111, 8'hFF, mk(1,0,0,0,0,0,2'b00,0,0,2'b11,3'b0), 1'b0});
    rows.push_back('{7'b0010111, 8'hFF, mk(1,0,0,0,0,0,2'b01,0,1,2'b00,3'b0), 1'b0});
`ifdef CU_SYSTEM_EN
    rows.push_back('{7'b0001111, 8'hFF, 15'd0, 1'b0});
    rows.push_back('{7'b1110011, 8'hFF, 15'd0, 1'b0});
`endif

    // Legal encodings first so the flag checks stay meaningful, then illegal ones.
    vecs.push_back(v("r_add",   7'b0110011, 3'b000, 7'h00, mk(1,0,0,0,0,0,2'b00,1,0,2'b00,3'b000), 0));
    vecs.push_back(v("r_sub",   7'b0110011, 3'b000, 7'h20, mk(1,0,0,0,0,0,2'b00,1,0,2'b00,3'b000), 0));
    vecs.push_back(v("r_sra",   7'b0110011, 3'b101, 7'h20, mk(1,0,0,0,0,0,2'b00,1,0,2'b00,3'b000), 0));
    vecs.push_back(v("i_addi",  7'b0010011, 3'b000, 7'h55, mk(1,0,0,0,0,0,2'b01,1,0,2'b00,3'b000), 0));
    vecs.push_back(v("i_slli",  7'b0010011, 3'b001, 7'h00, mk(1,0,0,0,0,0,2'b01,1,0,2'b00,3'b000), 0));
    vecs.push_back(v("i_srai",  7'b0010011, 3'b101, 7'h20, mk(1,0,0,0,0,0,2'b01,1,0,2'b00,3'b000), 0));
    vecs.push_back(v("ld_lbu",  7'b0000011, 3'b100, 7'h00, mk(1,0,0,0,1,0,2'b01,0,0,2'b01,3'b100), 0));
    vecs.push_back(v("st_sw",   7'b0100011, 3'b010, 7'h00, mk(0,1,0,0,0,0,2'b01,0,0,2'b00,3'b010), 0));
    vecs.push_back(v("br_bgeu", 7'b1100011, 3'b111, 7'h00, mk(0,0,0,0,0,1,2'b00,1,0,2'b00,3'b000), 0));
    vecs.push_back(v("jal",     7'b1101111, 3'b011, 7'h7F, mk(1,0,1,0,0,0,2'b00,0,0,2'b10,3'b000), 0));
    vecs.push_back(v("jalr",    7'b1100111, 3'b000, 7'h00, mk(1,0,1,1,0,0,2'b01,0,0,2'b10,3'b000), 0));
    vecs.push_back(v("lui",     7'b0110111, 3'b110, 7'h11, mk(1,0,0,0,0,0,2'b00,0,0,2'b11,3'b000), 0));
    vecs.push_back(v("auipc",   7'b0010111, 3'b000, 7'h00, mk(1,0,0,0,0,0,2'b01,0,1,2'b00,3'b000), 0));
    vecs.push_back(v("jalr_f3", 7'b1100111, 3'b001, 7'h00, 15'd0, 1));
    vecs.push_back(v("r_f7bad", 7'b0110011, 3'b000, 7'h01, 15'd0, 1));
    vecs.push_back(v("r_altf3", 7'b0110011, 3'b001, 7'h20, 15'd0, 1));
    vecs.push_back(v("i_slli7", 7'b0010011, 3'b001, 7'h20, 15'd0, 1));
    vecs.push_back(v("i_sri7",  7'b0010011, 3'b101, 7'h01, 15'd0, 1));
    vecs.push_back(v("ld_011",  7'b0000011, 3'b011, 7'h00, 15'd0, 1));
    vecs.push_back(v("st_011",  7'b0100011, 3'b011, 7'h00, 15'd0, 1));
    vecs.push_back(v("br_010",  7'b1100011, 3'b010, 7'h00, 15'd0, 1));
    vecs.push_back(v("op_ff",   7'b1111111, 3'b000, 7'h00, 15'd0, 1));
    vecs.push_back(v("system",  7'b1110011, 3'b000, 7'h00, 15'd0, SYS_ILL));
    vecs.push_back(v("fence",   7'b0001111, 3'b000, 7'h00, 15'd0, SYS_ILL));

    OP = 7'b0110011; Funct3 = 3'd0; Funct7 = 7'd0; rst_n = 1'b0;
    @(posedge clk); #1;
    model_flag = 1'b0;
    check("reset.flag", {14'd0, IllegalInstr}, 15'd0);

    // System opcode alone from a clean flag: flag set only when not enabled.
    apply("sys_alone", 7'b1110011, 3'b000, 7'h00, 1'b0, 15'd0, 1'b0);
    apply("sys_only",  7'b1110011, 3'b000, 7'h00, 1'b1, 15'd0, SYS_ILL);
    apply("clr",       7'b0110011, 3'b000, 7'h00, 1'b0, mk(1,0,0,0,0,0,2'b00,1,0,2'b00,3'b0), 1'b0);

    foreach (vecs[i])
      apply(vecs[i].name, vecs[i].op, vecs[i].f3, vecs[i].f7, 1'b1, vecs[i].exp_o, vecs[i].ill);

    // Reset beats a coincident illegal encoding; release then sets and holds.
    apply("rst_ill",  7'b1111111, 3'b000, 7'h00, 1'b0, 15'd0, 1'b1);
    check("rst_ill.cleared", {14'd0, IllegalInstr}, 15'd0);
    apply("rel_ill",  7'b1111111, 3'b000, 7'h00, 1'b1, 15'd0, 1'b1);
    check("rel_ill.set", {14'd0, IllegalInstr}, 15'd1);
    apply("hold_lui", 7'b0110111, 3'b000, 7'h00, 1'b1, mk(1,0,0,0,0,0,2'b00,0,0,2'b11,3'b0), 1'b0);
    apply("hold_add", 7'b0110011, 3'b000, 7'h00, 1'b1, mk(1,0,0,0,0,0,2'b00,1,0,2'b00,3'b0), 1'b0);
    check("hold.still_set", {14'd0, IllegalInstr}, 15'd1);

    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111, 7'b1110011, 7'b0000000};
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] rf3;
      logic [6:0] rf7;
      bit         rn;
      if ($urandom_range(0, 3) != 0) rop = ops[$urandom_range(0, 11)];
      else rop = 7'($urandom);
      rf3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0: rf7 = 7'h00;
        1: rf7 = 7'h20;
        default: rf7 = 7'($urandom);
      endcase
      rn = ($urandom_range(0, 15) != 0);
      ref_model(rop, rf3, rf7, eo, ei);
      apply("rand", rop, rf3, rf7, rn, eo, ei);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
